// File: rtl/cache_arb_pkg.sv
// Shared types for the two-requester cache SRAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_arb_pkg;

    typedef enum logic {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_e;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // One slot of the read-return pipe: which requester gets the data back.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } ret_t;

endpackage

// File: rtl/cache_arb_rr.sv
// Two-way round-robin grant generator; owns the priority state.
// Latency: grants are combinational from the requests; priority updates at the edge.
// Backpressure: a losing requester simply sees no grant and keeps requesting.
module cache_arb_rr
    import cache_arb_pkg::*;
(
    input  logic Clk_CI,
    input  logic Rst_RBI,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    prio_e prio_q;
    prio_e prio_d;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            prio_q <= PRIO0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grants are forced low while reset is held so the SRAM port stays quiet.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        prio_d = prio_q;
        if (Rst_RBI) begin
            gnt0 = req0 & (~req1 | (prio_q == PRIO0));
            gnt1 = req1 & (~req0 | (prio_q == PRIO1));
        end
        if (gnt0) begin
            prio_d = PRIO1;
        end else if (gnt1) begin
            prio_d = PRIO0;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates two requesters onto one duplicated SRAM and routes read data back.
// Latency: grant same cycle; read data returns 1+OUT_REGS cycles after acceptance.
// Backpressure: req/gnt handshake; returns are never stalled.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int OUT_REGS   = 0
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,

    input  logic                  Req0_SI,
    output logic                  Gnt0_SO,
    input  logic                  WrEn0_SI,
    input  logic [7:0]            BEn0_SI,
    input  logic [63:0]           WrData0_DI,
    input  logic [ADDR_WIDTH-1:0] Addr0_DI,
    output logic                  RdValid0_SO,
    output logic [63:0]           RdData0_DO,

    input  logic                  Req1_SI,
    output logic                  Gnt1_SO,
    input  logic                  WrEn1_SI,
    input  logic [7:0]            BEn1_SI,
    input  logic [63:0]           WrData1_DI,
    input  logic [ADDR_WIDTH-1:0] Addr1_DI,
    output logic                  RdValid1_SO,
    output logic [63:0]           RdData1_DO,

    output logic                  CSel_SO,
    output logic                  WrEn_SO,
    output logic [7:0]            BEn_SO,
    output logic [63:0]           WrData_DO,
    output logic [ADDR_WIDTH-1:0] Addr_DO,
    input  logic [63:0]           RdData1_DI,
    input  logic [63:0]           RdData2_DI,
    output logic                  Mismatch_SO
);

    localparam int DEPTH = 1 + OUT_REGS;

    logic gnt0;
    logic gnt1;
    logic xfer;
    ret_t ret_in;
    ret_t ret_out;
    ret_t pipe_q [DEPTH];
    logic mismatch_q;

    cache_arb_rr u_rr (
        .Clk_CI  (Clk_CI),
        .Rst_RBI (Rst_RBI),
        .req0    (Req0_SI),
        .req1    (Req1_SI),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign Gnt0_SO = gnt0;
    assign Gnt1_SO = gnt1;
    assign xfer    = gnt0 | gnt1;

    always_comb begin
        CSel_SO   = 1'b0;
        WrEn_SO   = 1'b0;
        BEn_SO    = '0;
        WrData_DO = '0;
        Addr_DO   = '0;
        if (gnt1) begin
            CSel_SO   = 1'b1;
            WrEn_SO   = WrEn1_SI;
            BEn_SO    = BEn1_SI;
            WrData_DO = WrData1_DI;
            Addr_DO   = Addr1_DI;
        end else if (gnt0) begin
            CSel_SO   = 1'b1;
            WrEn_SO   = WrEn0_SI;
            BEn_SO    = BEn0_SI;
            WrData_DO = WrData0_DI;
            Addr_DO   = Addr0_DI;
        end
    end

    // Only reads occupy a return slot; the SRAM's own output stages set the depth.
    always_comb begin
        ret_in.vld = xfer & ~WrEn_SO;
        ret_in.id  = gnt1 ? REQ1 : REQ0;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= ret_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign ret_out = pipe_q[DEPTH-1];

    always_comb begin
        RdValid0_SO = ret_out.vld & (ret_out.id == REQ0);
        RdValid1_SO = ret_out.vld & (ret_out.id == REQ1);
        RdData0_DO  = RdValid0_SO ? RdData1_DI : '0;
        RdData1_DO  = RdValid1_SO ? RdData1_DI : '0;
    end

    // Copy disagreement is only meaningful on a returning read; sticky until reset.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            mismatch_q <= 1'b0;
        end else if (ret_out.vld && (RdData1_DI != RdData2_DI)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign Mismatch_SO = mismatch_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: one DUT with OUT_REGS=0 and one with OUT_REGS=1 on shared inputs.
module tb_cache_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, wren0, wren1;
    logic [7:0]  ben0, ben1, addr0, addr1;
    logic [63:0] wdata0, wdata1, rd1, rd2;

    logic        d0_gnt0, d0_gnt1, d0_rv0, d0_rv1, d0_csel, d0_wren, d0_mm;
    logic [63:0] d0_rd0, d0_rd1, d0_wdata;
    logic [7:0]  d0_ben, d0_addr;
    logic        d1_gnt0, d1_gnt1, d1_rv0, d1_rv1, d1_csel, d1_wren, d1_mm;
    logic [63:0] d1_rd0, d1_rd1, d1_wdata;
    logic [7:0]  d1_ben, d1_addr;

    int errors = 0;
    int checks = 0;

    cache_arbiter #(.ADDR_WIDTH(8), .OUT_REGS(0)) dut0 (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .Req0_SI(req0), .Gnt0_SO(d0_gnt0), .WrEn0_SI(wren0), .BEn0_SI(ben0),
        .WrData0_DI(wdata0), .Addr0_DI(addr0), .RdValid0_SO(d0_rv0), .RdData0_DO(d0_rd0),
        .Req1_SI(req1), .Gnt1_SO(d0_gnt1), .WrEn1_SI(wren1), .BEn1_SI(ben1),
        .WrData1_DI(wdata1), .Addr1_DI(addr1), .RdValid1_SO(d0_rv1), .RdData1_DO(d0_rd1),
        .CSel_SO(d0_csel), .WrEn_SO(d0_wren), .BEn_SO(d0_ben), .WrData_DO(d0_wdata),
        .Addr_DO(d0_addr), .RdData1_DI(rd1), .RdData2_DI(rd2), .Mismatch_SO(d0_mm)
    );

    cache_arbiter #(.ADDR_WIDTH(8), .OUT_REGS(1)) dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .Req0_SI(req0), .Gnt0_SO(d1_gnt0), .WrEn0_SI(wren0), .BEn0_SI(ben0),
        .WrData0_DI(wdata0), .Addr0_DI(addr0), .RdValid0_SO(d1_rv0), .RdData0_DO(d1_rd0),
        .Req1_SI(req1), .Gnt1_SO(d1_gnt1), .WrEn1_SI(wren1), .BEn1_SI(ben1),
        .WrData1_DI(wdata1), .Addr1_DI(addr1), .RdValid1_SO(d1_rv1), .RdData1_DO(d1_rd1),
        .CSel_SO(d1_csel), .WrEn_SO(d1_wren), .BEn_SO(d1_ben), .WrData_DO(d1_wdata),
        .Addr_DO(d1_addr), .RdData1_DI(rd1), .RdData2_DI(rd2), .Mismatch_SO(d1_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic idle();
        req0 = 0; req1 = 0; wren0 = 0; wren1 = 0;
        ben0 = 0; ben1 = 0; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rd1 = 64'h0; rd2 = 64'h0;
        req0 = 1; req1 = 1; addr0 = 8'h55; addr1 = 8'h66;
        @(negedge clk);
        checks++; if (d0_gnt0 !== 1'b0 || d0_gnt1 !== 1'b0) begin errors++;
            $display("FAIL reset_gnt: got gnt0=%0b gnt1=%0b want 0 0", d0_gnt0, d0_gnt1); end
        checks++; if (d0_csel !== 1'b0 || d0_addr !== 8'h00) begin errors++;
            $display("FAIL reset_sram: got csel=%0b addr=%h want 0 00", d0_csel, d0_addr); end
        checks++; if (d0_rv0 !== 1'b0 || d0_rv1 !== 1'b0 || d0_mm !== 1'b0) begin errors++;
            $display("FAIL reset_rv_mm: got rv0=%0b rv1=%0b mm=%0b want 0 0 0", d0_rv0, d0_rv1, d0_mm); end
        checks++; if (d1_gnt0 !== 1'b0 || d1_csel !== 1'b0 || d1_mm !== 1'b0) begin errors++;
            $display("FAIL reset_dut1: got gnt0=%0b csel=%0b mm=%0b want 0 0 0", d1_gnt0, d1_csel, d1_mm); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        req0 = 1; wren0 = 0; addr0 = 8'h05; rd1 = 64'hDEAD; rd2 = 64'hDEAD;
        @(negedge clk);
        checks++; if (d0_gnt0 !== 1'b1 || d0_gnt1 !== 1'b0) begin errors++;
            $display("FAIL single_gnt: got gnt0=%0b gnt1=%0b want 1 0", d0_gnt0, d0_gnt1); end
        checks++; if (d0_csel !== 1'b1 || d0_wren !== 1'b0 || d0_addr !== 8'h05) begin errors++;
            $display("FAIL single_port: got csel=%0b wren=%0b addr=%h want 1 0 05", d0_csel, d0_wren, d0_addr); end
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        checks++; if (d0_rv0 !== 1'b1 || d0_rd0 !== 64'hDEAD || d0_rv1 !== 1'b0) begin errors++;
            $display("FAIL single_ret: got rv0=%0b rd0=%h rv1=%0b want 1 dead 0", d0_rv0, d0_rd0, d0_rv1); end
        checks++; if (d1_rv0 !== 1'b0) begin errors++;
            $display("FAIL single_ret_lat2_early: got rv0=%0b want 0", d1_rv0); end
        @(negedge clk);
        checks++; if (d0_rv0 !== 1'b0 || d0_rd0 !== 64'h0) begin errors++;
            $display("FAIL single_ret_once: got rv0=%0b rd0=%h want 0 0", d0_rv0, d0_rd0); end
        checks++; if (d1_rv0 !== 1'b1 || d1_rd0 !== 64'hDEAD) begin errors++;
            $display("FAIL single_ret_lat2: got rv0=%0b rd0=%h want 1 dead", d1_rv0, d1_rd0); end
    endtask

    task automatic test_round_robin();
        logic exp1;
        logic prev;
        do_reset();
        prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req0 = 1; req1 = 1; wren0 = 0; wren1 = 0; addr0 = 8'h20; addr1 = 8'h30;
            @(negedge clk);
            exp1 = (k % 2 == 1);
            checks++; if (d0_gnt0 !== ~exp1 || d0_gnt1 !== exp1) begin errors++;
                $display("FAIL rr_gnt[%0d]: got gnt0=%0b gnt1=%0b want %0b %0b", k, d0_gnt0, d0_gnt1, ~exp1, exp1); end
            checks++; if (d0_csel !== 1'b1 || d0_addr !== (exp1 ? 8'h30 : 8'h20)) begin errors++;
                $display("FAIL rr_port[%0d]: got csel=%0b addr=%h", k, d0_csel, d0_addr); end
            if (k > 0) begin
                checks++; if (d0_rv0 !== ~prev || d0_rv1 !== prev) begin errors++;
                    $display("FAIL rr_ret[%0d]: got rv0=%0b rv1=%0b want %0b %0b", k, d0_rv0, d0_rv1, ~prev, prev); end
            end
            prev = exp1;
        end
        @(posedge clk); #1;
        idle();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        req0 = 1; wren0 = 1; ben0 = 8'h0F; wdata0 = 64'h1122334455667788; addr0 = 8'h10;
        @(negedge clk);
        checks++; if (d0_csel !== 1'b1 || d0_wren !== 1'b1 || d0_ben !== 8'h0F) begin errors++;
            $display("FAIL wr_ctrl: got csel=%0b wren=%0b ben=%h want 1 1 0f", d0_csel, d0_wren, d0_ben); end
        checks++; if (d0_wdata !== 64'h1122334455667788 || d0_addr !== 8'h10) begin errors++;
            $display("FAIL wr_data: got wdata=%h addr=%h want 1122334455667788 10", d0_wdata, d0_addr); end
        @(posedge clk); #1;
        idle();
        req1 = 1; wren1 = 1; ben1 = 8'h00; wdata1 = 64'hCAFE; addr1 = 8'h11;
        @(negedge clk);
        checks++; if (d0_gnt1 !== 1'b1 || d0_csel !== 1'b1 || d0_ben !== 8'h00 || d0_wdata !== 64'hCAFE) begin errors++;
            $display("FAIL wr_ben0: got gnt1=%0b csel=%0b ben=%h wdata=%h want 1 1 00 cafe", d0_gnt1, d0_csel, d0_ben, d0_wdata); end
        @(posedge clk); #1;
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({d0_rv0, d0_rv1, d1_rv0, d1_rv1} !== 4'b0000) begin errors++;
                $display("FAIL wr_no_rv[%0d]: got %b want 0000", k, {d0_rv0, d0_rv1, d1_rv0, d1_rv1}); end
        end
        checks++; if (d0_csel !== 1'b0 || d0_wren !== 1'b0 || d0_wdata !== 64'h0 || d0_addr !== 8'h00) begin errors++;
            $display("FAIL idle_port: got csel=%0b wren=%0b wdata=%h addr=%h want all 0", d0_csel, d0_wren, d0_wdata, d0_addr); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        req0 = 1; wren0 = 0; addr0 = 8'h01; rd1 = 64'hA0; rd2 = 64'hA0;
        @(negedge clk);
        checks++; if (d0_gnt0 !== 1'b1) begin errors++;
            $display("FAIL b2b_gnt0: got %0b want 1", d0_gnt0); end
        @(posedge clk); #1;
        req0 = 0; req1 = 1; wren1 = 0; addr1 = 8'h02; rd1 = 64'hA1; rd2 = 64'hA1;
        @(negedge clk);
        checks++; if (d0_gnt1 !== 1'b1 || d0_rv0 !== 1'b1 || d0_rd0 !== 64'hA1) begin errors++;
            $display("FAIL b2b_c1: got gnt1=%0b rv0=%0b rd0=%h want 1 1 a1", d0_gnt1, d0_rv0, d0_rd0); end
        checks++; if (d1_rv0 !== 1'b0) begin errors++;
            $display("FAIL b2b_c1_lat2: got rv0=%0b want 0", d1_rv0); end
        @(posedge clk); #1;
        req1 = 0; rd1 = 64'hA2; rd2 = 64'hA2;
        @(negedge clk);
        checks++; if (d0_rv1 !== 1'b1 || d0_rd1 !== 64'hA2 || d0_rv0 !== 1'b0) begin errors++;
            $display("FAIL b2b_c2: got rv1=%0b rd1=%h rv0=%0b want 1 a2 0", d0_rv1, d0_rd1, d0_rv0); end
        checks++; if (d1_rv0 !== 1'b1 || d1_rd0 !== 64'hA2 || d1_rv1 !== 1'b0) begin errors++;
            $display("FAIL b2b_c2_lat2: got rv0=%0b rd0=%h rv1=%0b want 1 a2 0", d1_rv0, d1_rd0, d1_rv1); end
        @(posedge clk); #1;
        rd1 = 64'hA3; rd2 = 64'hA3;
        @(negedge clk);
        checks++; if (d1_rv1 !== 1'b1 || d1_rd1 !== 64'hA3 || d1_rv0 !== 1'b0) begin errors++;
            $display("FAIL b2b_c3_lat2: got rv1=%0b rd1=%h rv0=%0b want 1 a3 0", d1_rv1, d1_rd1, d1_rv0); end
        checks++; if (d0_rv1 !== 1'b0 || d0_rd1 !== 64'h0) begin errors++;
            $display("FAIL b2b_c3: got rv1=%0b rd1=%h want 0 0", d0_rv1, d0_rd1); end
    endtask

    task automatic test_mismatch();
        @(posedge clk); #1;
        req0 = 1; wren0 = 0; addr0 = 8'h07; rd1 = 64'h1; rd2 = 64'h3;
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        checks++; if (d0_rv0 !== 1'b1 || d0_mm !== 1'b0) begin errors++;
            $display("FAIL mm_before: got rv0=%0b mm=%0b want 1 0", d0_rv0, d0_mm); end
        @(negedge clk);
        checks++; if (d0_mm !== 1'b1) begin errors++;
            $display("FAIL mm_set: got %0b want 1", d0_mm); end
        @(posedge clk); #1;
        rd2 = 64'h1;
        @(negedge clk);
        checks++; if (d1_mm !== 1'b1) begin errors++;
            $display("FAIL mm_set_lat2: got %0b want 1", d1_mm); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (d0_mm !== 1'b1 || d1_mm !== 1'b1) begin errors++;
            $display("FAIL mm_sticky: got d0=%0b d1=%0b want 1 1", d0_mm, d1_mm); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req0 = 1; wren0 = 0; addr0 = 8'h09; rd1 = 64'h77; rd2 = 64'h77;
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (d0_rv0 !== 1'b0 || d1_rv0 !== 1'b0 || d0_mm !== 1'b0 || d1_mm !== 1'b0) begin errors++;
            $display("FAIL rst_mid_during: got rv0=%0b/%0b mm=%0b/%0b want all 0", d0_rv0, d1_rv0, d0_mm, d1_mm); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (d0_rv0 !== 1'b0 || d1_rv0 !== 1'b0) begin errors++;
                $display("FAIL rst_mid_flush[%0d]: got rv0=%0b/%0b want 0 0", k, d0_rv0, d1_rv0); end
        end
        @(posedge clk); #1;
        req0 = 1; req1 = 1;
        @(negedge clk);
        checks++; if (d0_gnt0 !== 1'b1 || d0_gnt1 !== 1'b0 || d1_gnt0 !== 1'b1 || d1_gnt1 !== 1'b0) begin errors++;
            $display("FAIL rst_mid_prio: got d0 %0b%0b d1 %0b%0b want 10 10", d0_gnt0, d0_gnt1, d1_gnt0, d1_gnt1); end
        @(posedge clk); #1;
        idle();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_back_to_back();
        test_mismatch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
